pipe_stage_buf: RTL and testbench

//  Parametrised inter-stage pipeline buffer for the 5-stage core; carries one opaque packed payload
//  (fetch_data_t, decode_data_t, execute_data_t, ...) between stages.

---
 rtl/pipe_stage_buf_pkg.sv | 59 +++++
 rtl/pipe_stage_buf.sv | 102 ++++++++++
 tb/tb_pipe_stage_buf.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline-stage payload types and widths for the 5-stage core buffers.
// Each stage boundary sizes its pipe_stage_buf with the matching *_W localparam.
package pipe_stage_buf_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
    logic [30:0] pred_target;
  } fetch_data_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic [5:0]  op;
  } decode_data_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
  } execute_data_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wb_en;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [4:0]  rd;
  } writeback_data_t;

  localparam int FETCH_W     = $bits(fetch_data_t);
  localparam int DECODE_W    = $bits(decode_data_t);
  localparam int EXECUTE_W   = $bits(execute_data_t);
  localparam int MEMORY_W    = $bits(memory_data_t);
  localparam int WRITEBACK_W = $bits(writeback_data_t);

  // Occupancy update selected each cycle.
  typedef enum logic [1:0] {
    UPD_HOLD = 2'b00,
    UPD_INC  = 2'b01,
    UPD_DEC  = 2'b10
  } cnt_upd_e;

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready buffer between core pipeline stages: DEPTH-entry circular
// store, synchronous flush for redirects, optional zero-latency bypass when empty.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int DATA_W = FETCH_W,
  parameter int DEPTH  = 2,
  parameter int BYPASS = 0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic            BYP_EN   = (BYPASS != 32'sd0);

  // DEPTH need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == LAST_PTR) nxt = {PTR_W{1'b0}};
    else                 nxt = ptr + PTR_W'(1);
    return nxt;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              bypass_s;
  logic              push_s;
  logic              pop_s;
  logic              pass_s;
  logic              wr_en_s;
  logic              rd_en_s;
  cnt_upd_e          upd_s;

  // Handshake, output select and storage update decode.
  always_comb begin
    in_ready  = (count_r != FULL_CNT);
    bypass_s  = BYP_EN && (count_r == {CNT_W{1'b0}});
    out_valid = 1'b0;
    out_data  = mem[rd_ptr_r];
    if (bypass_s) begin
      out_valid = in_valid & ~flush;
      out_data  = in_data;
    end else begin
      // In bypass builds a redirect must never let a shadow item escape.
      out_valid = (count_r != {CNT_W{1'b0}}) & ~(BYP_EN & flush);
      out_data  = mem[rd_ptr_r];
    end
    push_s  = in_valid & in_ready;
    pop_s   = out_valid & out_ready;
    pass_s  = bypass_s & pop_s;
    wr_en_s = push_s & ~pass_s & ~flush;
    rd_en_s = pop_s & ~pass_s & ~flush;
    case ({wr_en_s, rd_en_s})
      2'b10:   upd_s = UPD_INC;
      2'b01:   upd_s = UPD_DEC;
      default: upd_s = UPD_HOLD;
    endcase
  end

  // Pointer and occupancy registers; flush returns to the reset state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (rd_en_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case (upd_s)
        UPD_INC: count_r <= count_r + CNT_W'(1);
        UPD_DEC: count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem[wr_ptr_r] <= in_data;
  end

  assign occupancy = count_r;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives three buffer configurations (D2/no bypass, D3/no bypass, D2/bypass) with
// shared stimulus and checks each against a queue-based model every cycle.
module tb_pipe_stage_buf;

  localparam int W  = 8;
  localparam int NI = 3;

  int dep_a [NI] = '{2, 3, 2};
  int byp_a [NI] = '{0, 0, 1};

  logic         clk       = 1'b0;
  logic         resetn    = 1'b0;
  logic         flush     = 1'b0;
  logic         in_valid  = 1'b0;
  logic [W-1:0] in_data   = 8'h00;
  logic         out_ready = 1'b0;

  logic         ir  [NI];
  logic         ov  [NI];
  logic [W-1:0] od  [NI];
  logic [1:0]   occ [NI];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(W), .DEPTH(2), .BYPASS(0)) dut0 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .occupancy(occ[0]));
  pipe_stage_buf #(.DATA_W(W), .DEPTH(3), .BYPASS(0)) dut1 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .occupancy(occ[1]));
  pipe_stage_buf #(.DATA_W(W), .DEPTH(2), .BYPASS(1)) dut2 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .occupancy(occ[2]));

  // Reference model: an ordered list of held items per instance.
  logic [W-1:0] mq   [NI][0:7];
  int           mcnt [NI] = '{0, 0, 0};
  logic         exp_ir  [NI];
  logic         exp_ov  [NI];
  logic [W-1:0] exp_od  [NI];
  logic [1:0]   exp_occ [NI];

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      exp_ir[i]  = (mcnt[i] != dep_a[i]);
      exp_occ[i] = 2'(mcnt[i]);
      if (byp_a[i] != 0 && mcnt[i] == 0) begin
        exp_ov[i] = in_valid && !flush;
        exp_od[i] = in_data;
      end else begin
        exp_ov[i] = (mcnt[i] != 0) && !(byp_a[i] != 0 && flush);
        exp_od[i] = mq[i][0];
      end
    end
  end

  always @(posedge clk or negedge resetn) begin
    for (int i = 0; i < NI; i++) begin
      if (!resetn || flush) begin
        mcnt[i] <= 0;
      end else begin
        automatic bit push = in_valid && exp_ir[i];
        automatic bit pop  = exp_ov[i] && out_ready;
        if (!(byp_a[i] != 0 && mcnt[i] == 0 && pop)) begin
          if (pop) for (int k = 0; k < 7; k++) mq[i][k] <= mq[i][k+1];
          if (push) mq[i][mcnt[i] - (pop ? 1 : 0)] <= in_data;
          mcnt[i] <= mcnt[i] + (push ? 1 : 0) - (pop ? 1 : 0);
        end
      end
    end
  end

  task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got=%0h expected=%0h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check("in_ready", i, 32'(ir[i]), 32'(exp_ir[i]));
      check("occupancy", i, 32'(occ[i]), 32'(exp_occ[i]));
      check("out_valid", i, 32'(ov[i]), 32'(exp_ov[i]));
      if (exp_ov[i]) check("out_data", i, 32'(od[i]), 32'(exp_od[i]));
    end
  end

  task automatic step(input logic iv, input logic [W-1:0] d, input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
  endtask

  initial begin
    // Reset held with in_valid asserted.
    step(1'b1, 8'h55, 1'b0, 1'b0);
    check("rst_ov", 0, 32'(ov[0]), 32'd0);
    check("rst_ir", 0, 32'(ir[0]), 32'd1);
    check("rst_occ", 0, 32'(occ[0]), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    resetn = 1'b1;

    // Streaming with out_ready high.
    step(1'b1, 8'h11, 1'b1, 1'b0);
    check("bypass_same_cycle", 2, 32'(od[2]), 32'h11);
    step(1'b1, 8'h22, 1'b1, 1'b0);
    check("stream_d1", 0, 32'(od[0]), 32'h11);
    check("stream_occ", 0, 32'(occ[0]), 32'd1);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    check("stream_d2", 0, 32'(od[0]), 32'h22);
    check("stream_ir", 0, 32'(ir[0]), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("stream_d3", 0, 32'(od[0]), 32'h33);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Back-pressure and wrap on the depth-3 instance.
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    step(1'b1, 8'h0B, 1'b0, 1'b0);
    step(1'b1, 8'h0C, 1'b0, 1'b0);
    step(1'b1, 8'h0D, 1'b0, 1'b0);
    check("full_occ", 1, 32'(occ[1]), 32'd3);
    check("full_ir", 1, 32'(ir[1]), 32'd0);
    step(1'b1, 8'h0D, 1'b1, 1'b0);
    check("drain_a", 1, 32'(od[1]), 32'h0A);
    step(1'b1, 8'h0D, 1'b1, 1'b0);
    check("drain_b", 1, 32'(od[1]), 32'h0B);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_c", 1, 32'(od[1]), 32'h0C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_d", 1, 32'(od[1]), 32'h0D);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_empty", 1, 32'(ov[1]), 32'd0);

    // Flush beats a simultaneous push and pop.
    step(1'b1, 8'h05, 1'b0, 1'b0);
    step(1'b1, 8'h06, 1'b0, 1'b0);
    step(1'b1, 8'h07, 1'b1, 1'b1);
    check("flush_byp_ov", 2, 32'(ov[2]), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("flush_ov", 0, 32'(ov[0]), 32'd0);
    check("flush_occ", 0, 32'(occ[0]), 32'd0);

    // Bypass pass-through, then held when out_ready is low.
    step(1'b1, 8'h99, 1'b1, 1'b0);
    check("byp_ov", 2, 32'(ov[2]), 32'd1);
    check("byp_od", 2, 32'(od[2]), 32'h99);
    check("byp_occ", 2, 32'(occ[2]), 32'd0);
    step(1'b1, 8'h98, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("byp_held_occ", 2, 32'(occ[2]), 32'd1);
    check("byp_held_od", 2, 32'(od[2]), 32'h98);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset pulse while full.
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_rst_occ", 0, 32'(occ[0]), 32'd2);
    #1 resetn = 1'b0;
    #1;
    check("async_occ", 0, 32'(occ[0]), 32'd0);
    check("async_ov", 0, 32'(ov[0]), 32'd0);
    check("async_ir", 0, 32'(ir[0]), 32'd1);
    #1 resetn = 1'b1;
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst_data", 0, 32'(od[0]), 32'h42);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomised traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
